// File: rtl/alu_pkg.sv
// Shared ALU definitions: command codes, flag layout, error codes and
// small counting helpers used by the datapath.
package alu_pkg;

    localparam logic [4:0] CMD_ZERO     = 5'b00000;
    localparam logic [4:0] CMD_SIGN     = 5'b00001;
    localparam logic [4:0] CMD_PASSFLAG = 5'b00010;
    localparam logic [4:0] CMD_LOADFLAG = 5'b00011;
    localparam logic [4:0] CMD_INV      = 5'b00100;
    localparam logic [4:0] CMD_OR       = 5'b00101;
    localparam logic [4:0] CMD_AND      = 5'b00110;
    localparam logic [4:0] CMD_XOR      = 5'b00111;
    localparam logic [4:0] CMD_ADD      = 5'b01000;
    localparam logic [4:0] CMD_SUB      = 5'b01001;
    localparam logic [4:0] CMD_ADC      = 5'b01010;
    localparam logic [4:0] CMD_SBB      = 5'b01011;
    localparam logic [4:0] CMD_NEG      = 5'b01100;
    localparam logic [4:0] CMD_SHL      = 5'b01101;
    localparam logic [4:0] CMD_SHR      = 5'b01110;
    localparam logic [4:0] CMD_SAR      = 5'b01111;
    localparam logic [4:0] CMD_ROL      = 5'b10000;
    localparam logic [4:0] CMD_ROR      = 5'b10001;
    localparam logic [4:0] CMD_CMP      = 5'b10010;
    localparam logic [4:0] CMD_MUL      = 5'b10011;
    localparam logic [4:0] CMD_MIN      = 5'b10100;
    localparam logic [4:0] CMD_MAX      = 5'b10101;
    localparam logic [4:0] CMD_PASSA    = 5'b10110;
    localparam logic [4:0] CMD_PASSB    = 5'b10111;
    localparam logic [4:0] CMD_POPCNT   = 5'b11000;
    localparam logic [4:0] CMD_CLZ      = 5'b11001;
    localparam logic [4:0] CMD_INC      = 5'b11010;
    localparam logic [4:0] CMD_DEC      = 5'b11011;
    localparam logic [4:0] CMD_NOP      = 5'b11111;

    localparam int OPM_SIGNED   = 0;
    localparam int OPM_FLAG_WE  = 1;

    localparam int FLAG_C       = 8;
    localparam int FLAG_N       = 9;
    localparam int FLAG_V       = 10;
    localparam int FLAG_Z       = 11;
    localparam int FLAG_P       = 12;
    localparam int FLAG_ERR_LO  = 16;

    localparam logic [63:0] FLAG_MASK = 64'h0000_0000_0007_1F7F;
    localparam logic [63:0] MIN_S64   = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAX_S64   = 64'h7FFF_FFFF_FFFF_FFFF;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL = 3'd1;
    localparam logic [2:0] ERR_OPM     = 3'd2;

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) n = n + {6'd0, v[i]};
        return n;
    endfunction

    function automatic logic [6:0] clz64(input logic [63:0] v);
        logic [6:0] n;
        logic       found;
        n     = 7'd0;
        found = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 7'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/command/result bundle between an ALU client and the ALU.
interface alu_if;
    logic [6:0]  opm;
    logic [4:0]  cmd;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out;
    logic [63:0] error;
    logic [63:0] regF;

    modport master (output opm, cmd, a, b, input out, error, regF);
    modport slave  (input opm, cmd, a, b, output out, error, regF);
endinterface

// File: rtl/alu_flag_reg.sv
// Flag register: synchronous reset, direct load, or capture of computed flags.
module alu_flag_reg
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        upd_en,
    input  logic [63:0] load_val,
    input  logic [63:0] upd_val,
    output logic [63:0] flags
);

    // Load wins over update; unmapped bits are forced to zero either way.
    always_ff @(posedge clk) begin
        if (rst)          flags <= '0;
        else if (load_en) flags <= load_val & FLAG_MASK;
        else if (upd_en)  flags <= upd_val & FLAG_MASK;
    end

endmodule

// File: rtl/alu.sv
// 64-bit ALU: combinational datapath and error decode; flags are captured
// by alu_flag_reg on the rising clock edge.
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    logic [63:0] res;
    logic [63:0] flag_src;
    logic [63:0] new_flags;
    logic [64:0] wide;
    logic [5:0]  sh;
    logic [5:0]  sh_m1;
    logic [5:0]  sh_neg;
    logic [6:0]  sh_inv;
    logic [2:0]  err;
    logic        c_f, v_f, lt, carry_in, load_en, upd_en;

    assign sh       = bus.b[5:0];
    assign sh_m1    = sh - 6'd1;
    assign sh_neg   = 6'd0 - sh;
    assign sh_inv   = 7'd64 - {1'b0, sh};
    assign carry_in = bus.regF[FLAG_C];
    assign lt       = bus.opm[OPM_SIGNED] ? ($signed(bus.a) < $signed(bus.b)) : (bus.a < bus.b);

    always_comb begin
        res  = '0;
        wide = '0;
        c_f  = 1'b0;
        v_f  = 1'b0;
        err  = ERR_NONE;
        case (bus.cmd)
            CMD_ZERO:     res = '0;
            CMD_SIGN: begin
                if (bus.b == '0)                             res = '0;
                else if (bus.opm[OPM_SIGNED] && bus.b[63])   res = '1;
                else                                         res = 64'd1;
            end
            CMD_PASSFLAG: res = bus.regF;
            CMD_LOADFLAG: res = bus.a & FLAG_MASK;
            CMD_INV:      res = ~bus.a;
            CMD_OR:       res = bus.a | bus.b;
            CMD_AND:      res = bus.a & bus.b;
            CMD_XOR:      res = bus.a ^ bus.b;
            CMD_ADD, CMD_ADC: begin
                wide = {1'b0, bus.a} + {1'b0, bus.b}
                     + {64'd0, (bus.cmd == CMD_ADC) & carry_in};
                res  = wide[63:0];
                c_f  = wide[64];
                v_f  = (bus.a[63] == bus.b[63]) && (res[63] != bus.a[63]);
            end
            CMD_SUB, CMD_SBB, CMD_CMP: begin
                wide = {1'b0, bus.a} - {1'b0, bus.b}
                     - {64'd0, (bus.cmd == CMD_SBB) & carry_in};
                res  = (bus.cmd == CMD_CMP) ? '0 : wide[63:0];
                c_f  = wide[64];
                v_f  = (bus.a[63] != bus.b[63]) && (wide[63] != bus.a[63]);
            end
            CMD_NEG: begin
                wide = 65'd0 - {1'b0, bus.a};
                res  = wide[63:0];
                c_f  = wide[64];
                v_f  = (bus.a == MIN_S64);
            end
            // Carry is the last bit to leave: a[64-n] for left, a[n-1] for right.
            CMD_SHL: begin
                res = bus.a << sh;
                c_f = (sh != 6'd0) && bus.a[sh_neg];
            end
            CMD_SHR: begin
                res = bus.a >> sh;
                c_f = (sh != 6'd0) && bus.a[sh_m1];
            end
            CMD_SAR: begin
                res = $signed(bus.a) >>> sh;
                c_f = (sh != 6'd0) && bus.a[sh_m1];
            end
            CMD_ROL: begin
                res = (bus.a << sh) | (bus.a >> sh_inv);
                c_f = (sh != 6'd0) && res[0];
            end
            CMD_ROR: begin
                res = (bus.a >> sh) | (bus.a << sh_inv);
                c_f = (sh != 6'd0) && res[63];
            end
            CMD_MUL:      res = bus.a * bus.b;
            CMD_MIN:      res = lt ? bus.a : bus.b;
            CMD_MAX:      res = lt ? bus.b : bus.a;
            CMD_PASSA:    res = bus.a;
            CMD_PASSB:    res = bus.b;
            CMD_POPCNT:   res = {57'd0, popcount64(bus.a)};
            CMD_CLZ:      res = {57'd0, clz64(bus.a)};
            CMD_INC: begin
                wide = {1'b0, bus.a} + 65'd1;
                res  = wide[63:0];
                c_f  = wide[64];
                v_f  = (bus.a == MAX_S64);
            end
            CMD_DEC: begin
                wide = {1'b0, bus.a} - 65'd1;
                res  = wide[63:0];
                c_f  = wide[64];
                v_f  = (bus.a == MIN_S64);
            end
            CMD_NOP:      res = '0;
            default:      err = ERR_ILLEGAL;
        endcase

        flag_src = (bus.cmd == CMD_CMP) ? wide[63:0] : res;
        if (bus.opm[6:2] != 5'd0) err = ERR_OPM;
        if (err != ERR_NONE) begin
            res      = '0;
            flag_src = '0;
            c_f      = 1'b0;
            v_f      = 1'b0;
        end
    end

    always_comb begin
        new_flags                     = '0;
        new_flags[6:0]                = bus.opm;
        new_flags[FLAG_C]             = c_f;
        new_flags[FLAG_N]             = flag_src[63];
        new_flags[FLAG_V]             = v_f;
        new_flags[FLAG_Z]             = (flag_src == '0);
        new_flags[FLAG_P]             = ~^flag_src[7:0];
        new_flags[FLAG_ERR_LO +: 3]   = err;
    end

    assign load_en   = (bus.cmd == CMD_LOADFLAG);
    assign upd_en    = bus.opm[OPM_FLAG_WE] && (bus.cmd != CMD_LOADFLAG)
                       && (bus.cmd != CMD_PASSFLAG) && (bus.cmd != CMD_NOP);
    assign bus.out   = res;
    assign bus.error = {61'd0, err};

    alu_flag_reg u_flag_reg (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .upd_en   (upd_en),
        .load_val (bus.a),
        .upd_val  (new_flags),
        .flags    (bus.regF)
    );

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed checks followed by random commands compared
// against an arithmetic reference model of results and flags.
module tb_alu;

    logic clk = 1'b0;
    logic rst;
    alu_if bus();

    alu dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [63:0] mf;
    localparam logic [63:0] MASK = 64'h71F7F;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void arith(input logic [63:0] x, input logic [63:0] y, input logic ci,
                                  input logic sub, output logic [63:0] r, output logic cy,
                                  output logic ov);
        logic signed [65:0] st;
        if (sub) begin
            r  = x - y - 64'(ci);
            cy = ({2'b00, y} + 66'(ci)) > {2'b00, x};
            st = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}) - $signed({65'd0, ci});
        end else begin
            r  = x + y + 64'(ci);
            cy = ({2'b00, x} + {2'b00, y} + 66'(ci)) > 66'h0_FFFF_FFFF_FFFF_FFFF;
            st = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, ci});
        end
        ov = (st != $signed({{2{r[63]}}, r}));
    endfunction

    function automatic void model(input logic [4:0] c, input logic [6:0] m, input logic [63:0] x,
                                  input logic [63:0] y, input logic [63:0] f,
                                  output logic [63:0] o, output logic [63:0] e,
                                  output logic [63:0] nf);
        logic [63:0] r, fs, d;
        logic cy, ov;
        int n;
        r = '0; d = '0; cy = 1'b0; ov = 1'b0;
        n = int'(y[5:0]);
        case (c)
            5'd1:  r = (y == 0) ? 64'd0 : ((m[0] && y[63]) ? '1 : 64'd1);
            5'd2:  r = f;
            5'd3:  r = x & MASK;
            5'd4:  r = ~x;
            5'd5:  r = x | y;
            5'd6:  r = x & y;
            5'd7:  r = x ^ y;
            5'd8:  arith(x, y, 1'b0, 1'b0, r, cy, ov);
            5'd9:  arith(x, y, 1'b0, 1'b1, r, cy, ov);
            5'd10: arith(x, y, f[8], 1'b0, r, cy, ov);
            5'd11: arith(x, y, f[8], 1'b1, r, cy, ov);
            5'd12: arith(64'd0, x, 1'b0, 1'b1, r, cy, ov);
            5'd13, 5'd14, 5'd15, 5'd16, 5'd17: begin
                r = x;
                for (int i = 0; i < n; i++) begin
                    case (c)
                        5'd13:   begin cy = r[63]; r = {r[62:0], 1'b0}; end
                        5'd14:   begin cy = r[0];  r = {1'b0, r[63:1]}; end
                        5'd15:   begin cy = r[0];  r = {r[63], r[63:1]}; end
                        5'd16:   begin cy = r[63]; r = {r[62:0], r[63]}; end
                        default: begin cy = r[0];  r = {r[0], r[63:1]}; end
                    endcase
                end
            end
            5'd18: arith(x, y, 1'b0, 1'b1, d, cy, ov);
            5'd19: r = x * y;
            5'd20: r = (m[0] ? ($signed(x) < $signed(y)) : (x < y)) ? x : y;
            5'd21: r = (m[0] ? ($signed(x) < $signed(y)) : (x < y)) ? y : x;
            5'd22: r = x;
            5'd23: r = y;
            5'd24: r = 64'($countones(x));
            5'd25: begin
                r = 64'd64;
                for (int i = 0; i < 64; i++) if (x[i]) r = 64'(63 - i);
            end
            5'd26: arith(x, 64'd1, 1'b0, 1'b0, r, cy, ov);
            5'd27: arith(x, 64'd1, 1'b0, 1'b1, r, cy, ov);
            default: r = '0;
        endcase
        fs = (c == 5'd18) ? d : r;
        e = 64'd0;
        if (m[6:2] != 5'd0) e = 64'd2;
        else if (c >= 5'd28 && c <= 5'd30) e = 64'd1;
        if (e != 0) begin r = '0; fs = '0; cy = 1'b0; ov = 1'b0; end
        nf = '0;
        nf[6:0]   = m;
        nf[8]     = cy;
        nf[9]     = fs[63];
        nf[10]    = ov;
        nf[11]    = (fs == 0);
        nf[12]    = ($countones(fs[7:0]) % 2) == 0;
        nf[18:16] = e[2:0];
        o = r;
    endfunction

    task automatic step(input logic [4:0] c, input logic [6:0] m, input logic [63:0] x,
                        input logic [63:0] y);
        logic [63:0] eo, ee, enf;
        bus.cmd = c; bus.opm = m; bus.a = x; bus.b = y;
        #1;
        model(c, m, x, y, mf, eo, ee, enf);
        chk($sformatf("out cmd=%0d opm=%0h a=%h b=%h", c, m, x, y), bus.out, eo);
        chk($sformatf("error cmd=%0d opm=%0h", c, m), bus.error, ee);
        @(posedge clk); #1;
        if (c == 5'd3) mf = x & MASK;
        else if (m[1] && c != 5'd2 && c != 5'd31) mf = enf;
        chk($sformatf("regF cmd=%0d opm=%0h", c, m), bus.regF, mf);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus.cmd = 5'd3; bus.opm = 7'd2; bus.a = '1; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset overrides load", bus.regF, 64'd0);
        mf = '0;
        rst = 1'b0;

        step(5'd2, 7'd0, 64'd0, 64'd0);
        chk("passflag after reset", bus.out, 64'd0);

        step(5'd3, 7'd0, 64'hFFFF, 64'd0);
        chk("loadflag ffff", bus.regF, 64'h1F7F);
        step(5'd3, 7'd0, 64'd0, 64'd0);
        chk("loadflag zero", bus.regF, 64'd0);

        step(5'd1, 7'd1, 64'd0, '1);
        chk("sign negative", bus.out, 64'hFFFF_FFFF_FFFF_FFFF);
        step(5'd1, 7'd1, 64'd0, 64'd0);
        chk("sign zero", bus.out, 64'd0);
        step(5'd1, 7'd0, 64'd0, '1);
        chk("sign unsigned", bus.out, 64'd1);

        step(5'd4, 7'd2, '1, 64'd0);
        chk("inv out", bus.out, 64'd0);
        chk("inv Z", 64'(bus.regF[11]), 64'd1);
        chk("inv N", 64'(bus.regF[9]), 64'd0);

        step(5'd5, 7'd0, 64'hF0F0F0, 64'h0F0F0F);
        chk("or out", bus.out, 64'hFFFFFF);
        chk("or error", bus.error, 64'd0);

        step(5'd8, 7'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add out", bus.out, 64'h8000_0000_0000_0000);
        chk("add V", 64'(bus.regF[10]), 64'd1);
        chk("add N", 64'(bus.regF[9]), 64'd1);
        step(5'd28, 7'd0, 64'd5, 64'd5);
        chk("illegal code", bus.error, 64'd1);
        step(5'd28, 7'd4, 64'd5, 64'd5);
        chk("reserved opm", bus.error, 64'd2);

        step(5'd8, 7'd2, '1, 64'd1);
        chk("add carry", 64'(bus.regF[8]), 64'd1);
        step(5'd10, 7'd0, 64'd5, 64'd6);
        chk("adc uses C", bus.out, 64'd12);
        step(5'd11, 7'd0, 64'd5, 64'd3);
        chk("sbb uses C", bus.out, 64'd1);

        step(5'd13, 7'd2, 64'h8000_0000_0000_0001, 64'd0);
        chk("shl zero amount C", 64'(bus.regF[8]), 64'd0);
        step(5'd13, 7'd2, 64'h8000_0000_0000_0000, 64'd1);
        chk("shl C", 64'(bus.regF[8]), 64'd1);
        step(5'd25, 7'd0, 64'd0, 64'd0);
        chk("clz zero", bus.out, 64'd64);
        step(5'd18, 7'd2, 64'd3, 64'd3);
        chk("cmp out", bus.out, 64'd0);
        chk("cmp Z", 64'(bus.regF[11]), 64'd1);
        step(5'd29, 7'd2, 64'd7, 64'd7);
        chk("error flags", bus.regF, 64'h11802);

        bus.cmd = 5'd8; bus.opm = 7'd2; bus.a = '1; bus.b = 64'd1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("reset overrides update", bus.regF, 64'd0);
        mf = '0;
        rst = 1'b0;

        for (int i = 0; i < 500; i++) begin
            logic [4:0]  c;
            logic [6:0]  m;
            logic [63:0] x, y;
            c = 5'($urandom_range(0, 31));
            m = {5'd0, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) m[6:2] = 5'($urandom_range(1, 31));
            x = pick();
            y = pick();
            step(c, m, x, y);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  single clock; regF updates on rising edge only.
REQ-002 rst  input  1  synchronous active-high reset.
REQ-003 opm  input  7  operation mode: [0]=signed compare/sign semantics, [1]=flag write enable, [6:2] reserved (must be 0).
REQ-004 cmd  input  5  command code.
REQ-005 a  input  64  operand A.
REQ-006 b  input  64  operand B.
REQ-007 out  output  64  result, combinational from cmd/opm/a/b/regF.
REQ-008 error  output  64  error code, zero-extended, combinational.
REQ-009 regF  output  64  flag register contents.
REQ-010 No parameters; all ports always present.

Function
REQ-011 Commands: 00000 ZERO out=0; 00001 SIGN out=-1/0/+1 per b<0/b==0/b>0 (unsigned when opm[0]=0: 0 or 1); 00010 PASSFLAG out=regF; 00011 LOADFLAG out=a&FLAGMASK.
REQ-012 Commands: 00100 INV ~a; 00101 OR a|b; 00110 AND; 00111 XOR; 01000 ADD a+b; 01001 SUB a-b; 01010 ADC a+b+C; 01011 SBB a-b-C.
REQ-013 Commands: 01100 NEG -a; 01101 SHL a<<b[5:0]; 01110 SHR logical; 01111 SAR; 10000 ROL; 10001 ROR; 10010 CMP out=0, flags from a-b; 10011 MUL low 64 bits of a*b.
REQ-014 Commands: 10100 MIN; 10101 MAX (signedness per opm[0]); 10110 PASSA; 10111 PASSB; 11000 POPCNT(a); 11001 CLZ(a), 64 when a=0; 11010 INC a+1; 11011 DEC a-1; 11111 NOP out=0.
REQ-015 Codes 11100-11110 illegal: out=0, error=1.
REQ-016 opm[6:2]!=0: out=0, error=2 (takes priority over error=1); otherwise error=0.
REQ-017 FLAGMASK = bits [18:16],[12:8],[6:0]; all other regF bits always read 0.
REQ-018 regF fields: [8]=C carry/borrow-out, [9]=N result bit 63, [10]=V signed overflow, [11]=Z result==0, [12]=P even parity of result[7:0], [6:0]=opm of last flag write, [18:16]=error[2:0] of last flag write.
REQ-019 C/V defined for ADD/SUB/ADC/SBB/NEG/CMP/INC/DEC; C=last bit shifted out for shifts/rotates (0 if amount 0); C=V=0 for all others.
REQ-020 CMP flags computed from a-b although out=0.
REQ-021 Rising edge, rst=0, cmd=LOADFLAG: regF<=a&FLAGMASK regardless of opm[1].
REQ-022 Rising edge, rst=0, opm[1]=1, cmd not LOADFLAG/PASSFLAG/NOP: regF<=new flags; else regF holds.
REQ-023 ADC/SBB use C from current regF; result visible same cycle, flags next edge.
REQ-024 Errors still record flags when opm[1]=1 (Z=1, error code captured).

Reset
REQ-025 rst=1 at rising edge: regF<=0, overriding LOADFLAG and flag writes.
REQ-026 out/error stay combinational during reset; PASSFLAG reads 0 after reset edge.

Structure
REQ-027 Shared package alu_pkg: command code constants, flag bit indices, FLAGMASK, error codes.
REQ-028 One sub-module alu_flag_reg holding regF with reset/load/update logic; datapath combinational in alu.

Verification
REQ-029 Reset then cmd=00010 -> out=0, regF=0.
REQ-030 cmd=00011, a=64'hFFFF, one edge -> regF=64'h1F7F; then a=0, edge -> regF=0.
REQ-031 cmd=00001, opm[0]=1, b=-1 -> out=64'hFFFFFFFFFFFFFFFF; b=0 -> out=0.
REQ-032 cmd=00100, a=-1 -> out=0; opm=2, edge -> regF[11]=1, regF[9]=0.
REQ-033 cmd=00101, a=64'hF0F0F0, b=64'h0F0F0F -> out=64'hFFFFFF, error=0.
REQ-034 cmd=01000, opm=2, a=64'h7FFFFFFFFFFFFFFF, b=1, edge -> out=64'h8000000000000000, regF[10]=1, regF[9]=1; cmd=11100 -> error=1; opm=4 -> error=2.
